saida_dados_display: RTL and testbench
======================================

SAIDA_DADOS_DISPLAY -- requirements
Module: saida_dados_display

Interface
REQ-001 SHALL have a single clock `clock` and a reset `reset`; reset is synchronous and active-high.
REQ-002 SHALL have ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dado  in  32  two's-complement value to display
- pedidoSaida  in  1  output request from control unit; level-sampled
- ocupado  out  1  conversion in progress
- pronto  out  1  one-cycle pulse; display outputs just updated
- centena  out  4  BCD hundreds digit
- dezena  out  4  BCD tens digit
- unidade  out  4  BCD units digit
- indicaNegativo  out  1  displayed value is negative
- saturado  out  1  magnitude exceeded 999 (see Configuration)

Function
REQ-003 SHALL implement FSM states OCIOSO, CONVERTE and PUBLICA.
REQ-004 In OCIOSO with pedidoSaida=1 at edge N, SHALL:
- latch |dado| as 32-bit unsigned and sign = dado[31]
- clear the 40-bit BCD accumulator and the iteration counter
- enter CONVERTE
REQ-005 SHALL drive ocupado=1 in CONVERTE and PUBLICA, and 0 otherwise.
REQ-006 In CONVERTE, SHALL perform one double-dabble iteration per clock, 32 iterations total:
- add 3 to each BCD nibble that is >=5
- shift the combined {BCD, magnitude} register left by 1
REQ-007 After the 32nd iteration, SHALL enter PUBLICA.
REQ-008 In PUBLICA, SHALL update centena/dezena/unidade/indicaNegativo/saturado and assert pronto for exactly one cycle, then return to OCIOSO. Outputs change and pronto rises at edge N+33.
REQ-009 Magnitude of 0x80000000 SHALL be treated as 2147483648 (no overflow).
REQ-010 indicaNegativo SHALL be 1 only when the latched dado is <0; zero is never negative.
REQ-011 Display outputs SHALL hold the last published value between conversions.
REQ-012 pedidoSaida asserted while ocupado=1 SHALL be ignored; there is no queuing.
REQ-013 pedidoSaida held high SHALL start a new conversion on the first cycle back in OCIOSO (edge N+34 at earliest).
REQ-014 dado SHALL be sampled only on the acceptance edge; later changes to dado have no effect on the conversion in progress.

Reset
REQ-015 reset=1 at any edge SHALL force state OCIOSO and set the following to 0:
- centena, dezena, unidade
- indicaNegativo, saturado
- ocupado, pronto
- accumulator and counter
REQ-016 Reset during CONVERTE or PUBLICA SHALL abort the conversion with no pronto pulse.
REQ-017 Reset SHALL take priority over pedidoSaida on the same edge.

Configuration
REQ-018 Macro SATURACAO_DISPLAY_EN defined: if the magnitude exceeds 999, PUBLICA SHALL output digits 9,9,9 and saturado=1; otherwise it SHALL output the true digits and saturado=0.
REQ-019 Macro SATURACAO_DISPLAY_EN undefined: SHALL output the three least-significant BCD digits (magnitude mod 1000); saturado SHALL be tied to 0.
REQ-020 In both configurations, indicaNegativo and the timing SHALL be identical.

Verification
REQ-021 dado=123, one-cycle pedidoSaida -> at edge N+33: digits 1,2,3; indicaNegativo=0; pronto high exactly 1 cycle; ocupado high for edges N+1..N+33.
REQ-022 dado=0xFFFFFFD3 (-45) -> digits 0,4,5; indicaNegativo=1; saturado=0.
REQ-023 dado=1234 -> with macro: digits 9,9,9, saturado=1; without macro: digits 2,3,4, saturado=0.
REQ-024 dado=0x80000000 -> indicaNegativo=1; with macro: digits 9,9,9, saturado=1; without macro: digits 6,4,8.
REQ-025 Start dado=7:
- at N+10, pulse pedidoSaida with dado=500 -> ignored; at N+33 digits 0,0,7.
- then request 500, and pulse reset 20 cycles into the conversion -> all outputs 0, no pronto.
- a subsequent request with dado=500 -> digits 5,0,0 after 33 cycles.

Source files
------------

// File: rtl/saida_dados_display.sv
// Converts a 32-bit two's-complement value into three BCD display digits with a sign flag, using a double-dabble conversion.
// Optional build macro SATURACAO_DISPLAY_EN: clamps magnitudes above 999 to 9,9,9 and raises saturado.
module saida_dados_display (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dado,
  input  logic        pedidoSaida,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  centena,
  output logic [3:0]  dezena,
  output logic [3:0]  unidade,
  output logic        indicaNegativo,
  output logic        saturado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    PUBLICA  = 2'd2
  } estado_t;

  estado_t     estadoReg, estadoNext;
  logic [39:0] bcdReg;
  logic [31:0] magReg;
  logic        sinalReg;
  logic [5:0]  contReg;

  logic [31:0] magEntrada;
  logic [39:0] bcdAjustado;
  logic [71:0] deslocado;
  logic [3:0]  centenaNext, dezenaNext, unidadeNext;
  logic        saturadoNext;

  // Negating 0x80000000 wraps back to 0x80000000, which read as unsigned is the correct magnitude.
  assign magEntrada = dado[31] ? (~dado + 32'd1) : dado;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_ajuste
      assign bcdAjustado[gi*4 +: 4] = (bcdReg[gi*4 +: 4] >= 4'd5) ?
                                      (bcdReg[gi*4 +: 4] + 4'd3) : bcdReg[gi*4 +: 4];
    end
  endgenerate

  assign deslocado = {bcdAjustado, magReg} << 1;
  assign ocupado   = (estadoReg != OCIOSO);

  always_comb begin
    estadoNext = estadoReg;
    case (estadoReg)
      OCIOSO:   if (pedidoSaida) estadoNext = CONVERTE;
      CONVERTE: if (contReg == 6'd31) estadoNext = PUBLICA;
      PUBLICA:  estadoNext = OCIOSO;
      default:  estadoNext = OCIOSO;
    endcase
  end

`ifdef SATURACAO_DISPLAY_EN
  // Any nonzero digit from thousands upward means the magnitude exceeds 999.
  always_comb begin
    saturadoNext = |bcdReg[39:12];
    centenaNext  = saturadoNext ? 4'd9 : bcdReg[11:8];
    dezenaNext   = saturadoNext ? 4'd9 : bcdReg[7:4];
    unidadeNext  = saturadoNext ? 4'd9 : bcdReg[3:0];
  end
`else
  always_comb begin
    saturadoNext = 1'b0;
    centenaNext  = bcdReg[11:8];
    dezenaNext   = bcdReg[7:4];
    unidadeNext  = bcdReg[3:0];
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estadoReg      <= OCIOSO;
      bcdReg         <= '0;
      magReg         <= '0;
      sinalReg       <= 1'b0;
      contReg        <= '0;
      pronto         <= 1'b0;
      centena        <= '0;
      dezena         <= '0;
      unidade        <= '0;
      indicaNegativo <= 1'b0;
      saturado       <= 1'b0;
    end else begin
      estadoReg <= estadoNext;
      pronto    <= 1'b0;
      case (estadoReg)
        OCIOSO: begin
          if (pedidoSaida) begin
            magReg   <= magEntrada;
            sinalReg <= dado[31];
            bcdReg   <= '0;
            contReg  <= '0;
          end
        end
        CONVERTE: begin
          {bcdReg, magReg} <= deslocado;
          contReg          <= contReg + 6'd1;
        end
        PUBLICA: begin
          centena        <= centenaNext;
          dezena         <= dezenaNext;
          unidade        <= unidadeNext;
          saturado       <= saturadoNext;
          indicaNegativo <= sinalReg;
          pronto         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_saida_dados_display.sv
// Scoreboard bench for saida_dados_display: a stimulus process predicts each publish, and a monitor checks every cycle.
module tb_saida_dados_display;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dado;
  logic        pedidoSaida;
  logic        ocupado, pronto;
  logic [3:0]  centena, dezena, unidade;
  logic        indicaNegativo, saturado;

  saida_dados_display dut (
    .clock(clock), .reset(reset), .dado(dado), .pedidoSaida(pedidoSaida),
    .ocupado(ocupado), .pronto(pronto), .centena(centena), .dezena(dezena),
    .unidade(unidade), .indicaNegativo(indicaNegativo), .saturado(saturado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       cyc;
    logic [3:0] c, d, u;
    logic     neg, sat;
  } exp_t;

  exp_t fila[$];
  exp_t lastExp;
  int   cyc = 0;
  int   acceptCyc = -1000;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the signed value.
  function automatic exp_t modelo(input logic [31:0] d, input int quando);
    exp_t   e;
    longint m, v;
    m = (d[31]) ? -longint'($signed(d)) : longint'(d);
`ifdef SATURACAO_DISPLAY_EN
    if (m > 999) begin v = 999; e.sat = 1'b1; end
    else begin v = m; e.sat = 1'b0; end
`else
    v = m % 1000;
    e.sat = 1'b0;
`endif
    e.c   = 4'(v / 100);
    e.d   = 4'((v / 10) % 10);
    e.u   = 4'(v % 10);
    e.neg = ($signed(d) < 0);
    e.cyc = quando;
    return e;
  endfunction

  task automatic verifica(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nome, cyc, atual, esperado);
    end
  endtask

  // Drive inputs for the next edge and advance the model to that edge.
  task automatic passo(input logic r, input logic p, input logic [31:0] d);
    int proxima;
    reset = r; pedidoSaida = p; dado = d;
    proxima = cyc + 1;
    if (r) begin
      acceptCyc = -1000;
      fila.delete();
      lastExp = '{cyc: 0, c: 4'd0, d: 4'd0, u: 4'd0, neg: 1'b0, sat: 1'b0};
    end else if (p && proxima >= acceptCyc + 34) begin
      acceptCyc = proxima;
      fila.push_back(modelo(d, proxima + 33));
    end
    @(negedge clock); #1;
  endtask

  task automatic pedido(input logic [31:0] d, input int espera);
    passo(1'b0, 1'b1, d);
    for (int i = 0; i < espera; i++) passo(1'b0, 1'b0, $urandom);
  endtask

  always @(negedge clock) begin
    logic expPr, expOc;
    expPr = 1'b0;
    if (fila.size() > 0 && fila[0].cyc == cyc) begin
      lastExp = fila.pop_front();
      expPr = 1'b1;
      $display("publish cyc=%0d digits=%0d%0d%0d neg=%0b sat=%0b", cyc,
               lastExp.c, lastExp.d, lastExp.u, lastExp.neg, lastExp.sat);
    end
    expOc = (cyc >= acceptCyc) && (cyc <= acceptCyc + 32);
    verifica("pronto", int'(pronto), int'(expPr));
    verifica("ocupado", int'(ocupado), int'(expOc));
    verifica("centena", int'(centena), int'(lastExp.c));
    verifica("dezena", int'(dezena), int'(lastExp.d));
    verifica("unidade", int'(unidade), int'(lastExp.u));
    verifica("indicaNegativo", int'(indicaNegativo), int'(lastExp.neg));
    verifica("saturado", int'(saturado), int'(lastExp.sat));
  end

  initial begin
    logic [31:0] d;
    lastExp = '{cyc: 0, c: 4'd0, d: 4'd0, u: 4'd0, neg: 1'b0, sat: 1'b0};
    reset = 1'b1; pedidoSaida = 1'b0; dado = 32'd0;
    @(negedge clock); #1;
    passo(1'b1, 1'b1, 32'd55);
    passo(1'b0, 1'b0, 32'd0);

    // Directed values, including boundaries around 999 and the most negative input.
    pedido(32'd123, 36);
    pedido(32'hFFFF_FFD3, 36);
    pedido(32'd1234, 36);
    pedido(32'h8000_0000, 36);
    pedido(32'd0, 36);
    pedido(32'd999, 36);
    pedido(32'd1000, 36);
    pedido(32'hFFFF_FFFF, 36);
    pedido(32'h7FFF_FFFF, 36);

    // Request during conversion is ignored; reset mid-conversion aborts.
    pedido(32'd7, 9);
    pedido(32'd500, 30);
    pedido(32'd500, 19);
    passo(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) passo(1'b0, 1'b0, 32'd0);
    pedido(32'd500, 36);

    // Request held high with dado changing every cycle.
    for (int i = 0; i < 110; i++) passo(1'b0, 1'b1, $urandom_range(0, 2000));
    passo(1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 1500);
        1: d = -$urandom_range(0, 1500);
        2: d = $urandom;
        default: d = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd999;
      endcase
      passo($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, d);
    end

    for (int i = 0; i < 40; i++) passo(1'b0, 1'b0, 32'd0);
    verifica("scoreboard_drained", fila.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
